// File: rtl/dct_mac_if.sv
// Term/result bus for dct_mac_unit: the producer drives enable, start and terms,
// and the MAC returns the rounded sum.
interface dct_mac_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16,
  parameter int RWIDTH = 12
);
  logic                     ena;
  logic                     start;
  logic                     din_valid;
  logic signed [DWIDTH-1:0] din;
  logic signed [CWIDTH-1:0] coef;
  logic signed [RWIDTH-1:0] result;
  logic                     result_valid;

  modport master (
    output ena, start, din_valid, din, coef,
    input  result, result_valid
  );

  modport slave (
    input  ena, start, din_valid, din, coef,
    output result, result_valid
  );
endinterface

// File: rtl/dct_mac_unit.sv
// Pipelined 8-term signed multiply-accumulate for DCT rows, with rounding and scaling.
// Define DCT_MAC_SAT_EN to saturate the output; otherwise it wraps to RWIDTH bits.
module dct_mac_unit #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16,
  parameter int RWIDTH = 12,
  parameter int RSHIFT = 14
) (
  input  logic     clk,
  input  logic     rst,
  dct_mac_if.slave bus
);
  localparam int PWIDTH = DWIDTH + CWIDTH;
  localparam int AWIDTH = PWIDTH + 3;
  localparam int SWIDTH = AWIDTH + 1 - RSHIFT;

  localparam logic signed [AWIDTH:0] RND_BIAS =
    {{(AWIDTH - RSHIFT + 1){1'b0}}, 1'b1, {(RSHIFT - 1){1'b0}}};
  localparam logic signed [SWIDTH-1:0] RES_MAX =
    {{(SWIDTH - RWIDTH + 1){1'b0}}, {(RWIDTH - 1){1'b1}}};
  localparam logic signed [SWIDTH-1:0] RES_MIN =
    {{(SWIDTH - RWIDTH + 1){1'b1}}, {(RWIDTH - 1){1'b0}}};

  logic [2:0]               term_cnt_reg;
  logic signed [DWIDTH-1:0] s1_din_reg;
  logic signed [CWIDTH-1:0] s1_coef_reg;
  logic                     s1_valid_reg, s1_first_reg, s1_last_reg;
  logic signed [PWIDTH-1:0] s2_prod_reg;
  logic                     s2_valid_reg, s2_first_reg, s2_last_reg;
  logic signed [AWIDTH-1:0] acc_reg;
  logic                     s3_last_reg;
  logic signed [RWIDTH-1:0] result_reg;
  logic                     result_valid_reg;

  logic signed [AWIDTH:0]   acc_rnd;
  logic signed [SWIDTH-1:0] rnd_full;
  logic signed [RWIDTH-1:0] res_next;

  assign acc_rnd  = {acc_reg[AWIDTH-1], acc_reg} + RND_BIAS;
  // Keeping the upper bits of the signed sum is the arithmetic shift by RSHIFT.
  assign rnd_full = acc_rnd[AWIDTH:RSHIFT];

  always_comb begin
    res_next = rnd_full[RWIDTH-1:0];
`ifdef DCT_MAC_SAT_EN
    if (rnd_full > RES_MAX)
      res_next = RES_MAX[RWIDTH-1:0];
    else if (rnd_full < RES_MIN)
      res_next = RES_MIN[RWIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_cnt_reg     <= 3'd0;
      s1_din_reg       <= '0;
      s1_coef_reg      <= '0;
      s1_valid_reg     <= 1'b0;
      s1_first_reg     <= 1'b0;
      s1_last_reg      <= 1'b0;
      s2_prod_reg      <= '0;
      s2_valid_reg     <= 1'b0;
      s2_first_reg     <= 1'b0;
      s2_last_reg      <= 1'b0;
      acc_reg          <= '0;
      s3_last_reg      <= 1'b0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else if (bus.ena) begin
      s1_valid_reg <= bus.din_valid;
      if (bus.din_valid) begin
        s1_din_reg   <= bus.din;
        s1_coef_reg  <= bus.coef;
        // A start term restarts the count; any partial sum is simply overwritten.
        s1_first_reg <= bus.start || (term_cnt_reg == 3'd0);
        s1_last_reg  <= !bus.start && (term_cnt_reg == 3'd7);
        term_cnt_reg <= bus.start ? 3'd1 : term_cnt_reg + 3'd1;
      end

      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
      if (s1_valid_reg)
        s2_prod_reg <= PWIDTH'(s1_din_reg) * PWIDTH'(s1_coef_reg);

      if (s2_valid_reg)
        acc_reg <= s2_first_reg ? AWIDTH'(s2_prod_reg) : acc_reg + AWIDTH'(s2_prod_reg);
      s3_last_reg <= s2_valid_reg && s2_last_reg;

      result_valid_reg <= s3_last_reg;
      if (s3_last_reg)
        result_reg <= res_next;
    end
  end

  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
endmodule

// File: tb/tb_dct_mac_unit.sv
// Directed bench for dct_mac_unit: hand-computed sums, stalls, gaps, restarts and reset.
module tb_dct_mac_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_mac_if #(.DWIDTH(8), .CWIDTH(16), .RWIDTH(12)) bus ();

  dct_mac_unit #(.DWIDTH(8), .CWIDTH(16), .RWIDTH(12), .RSHIFT(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DCT_MAC_SAT_EN
  localparam int EXP_BIG = 2047;   // 2^25 scaled to 2048, clipped
`else
  localparam int EXP_BIG = -2048;  // 2048 wrapped into 12 bits
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc;
  int pulse_cyc[$];
  int pulse_res[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One clock cycle: drive inputs, record any ena-qualified result pulse at the negedge.
  task automatic cycle(input logic e, input logic s, input logic v, input int d, input int c);
    bus.ena       = e;
    bus.start     = s;
    bus.din_valid = v;
    bus.din       = d[7:0];
    bus.coef      = c[15:0];
    @(negedge clk);
    if (bus.ena && bus.result_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_res.push_back(int'(bus.result));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic terms(input logic first_start, input int n, input int d, input int c);
    for (int i = 0; i < n; i++) begin
      last_cyc = cyc;
      cycle(1'b1, first_start && (i == 0), 1'b1, d, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_res.delete();
  endtask

  function automatic int res_at(input int idx);
    return (pulse_res.size() > idx) ? pulse_res[idx] : -99999;
  endfunction

  function automatic int cyc_at(input int idx);
    return (pulse_cyc.size() > idx) ? pulse_cyc[idx] : -99999;
  endfunction

  initial begin
    bus.ena = 1'b0; bus.start = 1'b0; bus.din_valid = 1'b0; bus.din = '0; bus.coef = '0;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    check_val("reset_result", int'(bus.result), 0);
    check_val("reset_valid", int'(bus.result_valid), 0);

    // Eight unit terms: 8*16384 + 8192 >>> 14 = 8; valid visible 4 cycles after the 8th is driven.
    clear_mon();
    terms(1'b1, 8, 1, 16384);
    idle(6);
    check_val("basic_pulses", pulse_res.size(), 1);
    check_val("basic_result", res_at(0), 8);
    check_val("basic_latency", cyc_at(0) - last_cyc, 4);
    idle(3);
    check_val("hold_result", int'(bus.result), 8);
    check_val("hold_valid_low", int'(bus.result_valid), 0);

    // Full-scale negative product: 8 * 2^22 = 2^25 -> 2048 before clipping/wrapping.
    clear_mon();
    terms(1'b1, 8, -128, -32768);
    idle(6);
    check_val("big_pulses", pulse_res.size(), 1);
    check_val("big_result", res_at(0), EXP_BIG);

    // Partial sum of three terms is abandoned by a new start.
    clear_mon();
    terms(1'b1, 3, 5, 100);
    terms(1'b1, 8, 1, 16384);
    idle(6);
    check_val("restart_pulses", pulse_res.size(), 1);
    check_val("restart_result", res_at(0), 8);

    // Stalls every other cycle (with junk start/terms while stalled) plus din_valid gaps.
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 99, 1000);
      if (i == 2 || i == 5) cycle(1'b1, 1'b0, 1'b0, 77, 77);
      cycle(1'b1, i == 0, 1'b1, 1, 16384);
    end
    for (int j = 0; j < 12; j++) cycle(logic'(j % 2), 1'b0, 1'b0, 0, 0);
    check_val("stall_pulses", pulse_res.size(), 1);
    check_val("stall_result", res_at(0), 8);

    // Back-to-back sums: 8 then 2*8*16384 + 8192 >>> 14 = 16, pulses 8 cycles apart.
    clear_mon();
    terms(1'b1, 8, 1, 16384);
    terms(1'b0, 8, 2, 16384);
    idle(8);
    check_val("b2b_pulses", pulse_res.size(), 2);
    check_val("b2b_first", res_at(0), 8);
    check_val("b2b_second", res_at(1), 16);
    check_val("b2b_spacing", cyc_at(1) - cyc_at(0), 8);

    // Reset mid-sum (with ena low) clears outputs; next term is term 0 without start.
    clear_mon();
    terms(1'b1, 4, 1, 16384);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    check_val("midrst_result", int'(bus.result), 0);
    check_val("midrst_valid", int'(bus.result_valid), 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    check_val("postrst_result", int'(bus.result), 0);
    check_val("postrst_valid", int'(bus.result_valid), 0);
    terms(1'b0, 8, 1, 16384);
    check_val("postrst_hold_zero", int'(bus.result), 0);
    idle(6);
    check_val("postrst_pulses", pulse_res.size(), 1);
    check_val("postrst_sum", res_at(0), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dct_mac_unit.md
DCT_MAC_UNIT -- requirements
Module: dct_mac_unit

Interface
REQ-001 Parameter DWIDTH, 8, signed sample width of din.
REQ-002 Parameter CWIDTH, 16, signed coefficient width of coef.
REQ-003 Parameter RWIDTH, 12, signed result width.
REQ-004 Parameter RSHIFT, 14, arithmetic right shift applied to the final sum.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; ports: clk input 1 (rising-edge clock); rst input 1 (reset).
REQ-006 ena input 1: global clock enable; 0 stalls the whole block.
REQ-007 start input 1: marks the current term as term 0 of a new 8-term sum.
REQ-008 din_valid input 1: din/coef carry a term this cycle.
REQ-009 din input DWIDTH: signed sample.
REQ-010 coef input CWIDTH: signed cosine coefficient.
REQ-011 result output RWIDTH: signed, rounded, scaled 8-term sum.
REQ-012 result_valid output 1: result holds a new sum.

Function
REQ-013 A term SHALL be accepted on a rising edge where ena=1 and din_valid=1; with ena=0 nothing is accepted and every register holds.
REQ-014 The pipeline SHALL be S1 (input register), S2 (signed product, DWIDTH+CWIDTH bits), S3 (accumulator, DWIDTH+CWIDTH+3 bits), then the output register.
REQ-015 A 3-bit term counter SHALL count accepted terms 0..7 and wrap from 7 to 0, so 8 consecutive terms form one sum without start.
REQ-016 An accepted term with start=1 SHALL be term 0: the counter loads 1 and the partial sum in flight is discarded without producing result_valid.
REQ-017 start without din_valid, or with ena=0, SHALL be ignored.
REQ-018 First/last tags SHALL travel with each term; a first-tagged term loads the accumulator with its product, and other terms add to it.
REQ-019 When the last-tagged (8th) term is accumulated, the output register SHALL load on the next enabled edge with sat(round(acc)), where round(acc) = (acc + 2^(RSHIFT-1)) >>> RSHIFT.
REQ-020 Latency SHALL be 3 enabled edges from acceptance of the 8th term to result_valid=1.
REQ-021 result_valid SHALL be high for exactly one enabled cycle per completed sum; it holds its value across ena=0 stalls, and the consumer qualifies it with ena.
REQ-022 result SHALL hold its last value until the next completed sum.
REQ-023 Gaps (din_valid=0) inside a sum SHALL be allowed and SHALL NOT change the counter or accumulator.
REQ-024 Back-to-back sums with no idle cycle SHALL be supported at full rate of one term per cycle.

Reset
REQ-025 On a rising edge with rst=1, regardless of ena, the block SHALL clear all pipeline registers, tags, the counter and the accumulator, and drive result=0 and result_valid=0.
REQ-026 Reset in the middle of a sum SHALL discard that sum; the first accepted term after reset SHALL be term 0 even without start.

Configuration
REQ-027 With macro DCT_MAC_SAT_EN defined, the rounded value SHALL saturate to [-2^(RWIDTH-1), 2^(RWIDTH-1)-1].
REQ-028 Without DCT_MAC_SAT_EN, the rounded value SHALL be truncated to its RWIDTH LSBs (two's-complement wrap).

Verification
REQ-029 The bench SHALL cover: start on term 0, eight terms din=1, coef=16384 with ena=1 -> result=8, result_valid pulses once, 3 cycles after the 8th term.
REQ-030 The bench SHALL cover: eight terms din=-128, coef=-32768 -> result=2047 with DCT_MAC_SAT_EN, result=-2048 without.
REQ-031 The bench SHALL cover: three terms (din=5, coef=100), then start with eight terms din=1, coef=16384 -> a single result=8, with no valid for the partial sum.
REQ-032 The bench SHALL cover: eight terms din=1, coef=16384 with ena toggling 0/1 every cycle plus din_valid gaps -> result=8; result_valid is high for exactly one ena=1 cycle.
REQ-033 The bench SHALL cover: 16 back-to-back terms (the first with start; terms 0-7 din=1, coef=16384; terms 8-15 din=2, coef=16384) -> results 8 then 16 on consecutive valid pulses 8 cycles apart.
REQ-034 The bench SHALL cover: rst asserted after 4 terms, then 8 terms din=1, coef=16384 without start -> result=8, result/result_valid=0 during and immediately after reset.
